rpn_operand_stack: RTL and testbench

Operand stack for the 8-bit RPN calculator. Holds up to `DEPTH` 8-bit operands, executes one push/pop/binary-op/clear command per clock, and presents the top-of-stack byte as the value driven into the two-digit hex display decoder (high nibble to the tens digit, low nibble to the units digit). The second entry is exported as the ALU's B operand.

---
 rtl/rpn_operand_stack.sv | 136 +++++++++++++
 tb/tb_rpn_operand_stack.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/rpn_operand_stack.sv
// Operand stack for the 8-bit RPN calculator.
// Holds up to DEPTH operands as a shift register with s[0] as the top. Each
// cycle it executes one PUSH/POP/BINOP/CLEAR/SWAP command and reports any
// rejected command with a one-cycle err pulse and a sticky err_code.
// Optional feature macro: RPN_STACK_SWAP_EN makes cmd 101 exchange the top
// two entries. Without it, cmd 101 is treated as an illegal command.
module rpn_operand_stack #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [2:0] cmd,
  input  logic [7:0] din,
  output logic [7:0] top,
  output logic [7:0] second,
  output logic [3:0] depth,
  output logic       empty,
  output logic       full,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int unsigned DW  = 8;
  localparam int unsigned BOT = DEPTH - 1;
  localparam logic [3:0] DEPTH_L = 4'(DEPTH);

  localparam logic [2:0] CMD_NOP   = 3'b000;
  localparam logic [2:0] CMD_PUSH  = 3'b001;
  localparam logic [2:0] CMD_POP   = 3'b010;
  localparam logic [2:0] CMD_BINOP = 3'b011;
  localparam logic [2:0] CMD_CLEAR = 3'b100;
  localparam logic [2:0] CMD_SWAP  = 3'b101;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_OVER  = 2'b01;
  localparam logic [1:0] ERR_UNDER = 2'b10;
  localparam logic [1:0] ERR_ILL   = 2'b11;

  logic [DW-1:0] s_q [DEPTH];
  logic [DW-1:0] s_d [DEPTH];
  logic [3:0]    depth_d;
  logic          err_d;
  logic [1:0]    err_code_d;

  // Next-state decode of the current command; rejected commands leave storage alone.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) s_d[i] = s_q[i];
    depth_d    = depth;
    err_d      = 1'b0;
    err_code_d = err_code;
    if (cmd_valid) begin
      case (cmd)
        CMD_NOP: ;
        CMD_PUSH: begin
          if (depth == DEPTH_L) begin
            err_d      = 1'b1;
            err_code_d = ERR_OVER;
          end else begin
            for (int i = 1; i < int'(DEPTH); i++) s_d[i] = s_q[i-1];
            s_d[0]  = din;
            depth_d = depth + 4'd1;
          end
        end
        CMD_POP: begin
          if (depth == 4'd0) begin
            err_d      = 1'b1;
            err_code_d = ERR_UNDER;
          end else begin
            for (int i = 0; i < int'(BOT); i++) s_d[i] = s_q[i+1];
            s_d[BOT] = '0;
            depth_d  = depth - 4'd1;
          end
        end
        CMD_BINOP: begin
          if (depth < 4'd2) begin
            err_d      = 1'b1;
            err_code_d = ERR_UNDER;
          end else begin
            s_d[0] = din;
            for (int i = 1; i < int'(BOT); i++) s_d[i] = s_q[i+1];
            s_d[BOT] = '0;
            depth_d  = depth - 4'd1;
          end
        end
        CMD_CLEAR: begin
          for (int i = 0; i < int'(DEPTH); i++) s_d[i] = '0;
          depth_d    = 4'd0;
          err_code_d = ERR_NONE;
        end
`ifdef RPN_STACK_SWAP_EN
        CMD_SWAP: begin
          if (depth < 4'd2) begin
            err_d      = 1'b1;
            err_code_d = ERR_UNDER;
          end else begin
            s_d[0] = s_q[1];
            s_d[1] = s_q[0];
          end
        end
`endif
        default: begin
          err_d      = 1'b1;
          err_code_d = ERR_ILL;
        end
      endcase
    end
  end

  // State and flag registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) s_q[i] <= '0;
      depth    <= 4'd0;
      empty    <= 1'b1;
      full     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) s_q[i] <= s_d[i];
      depth    <= depth_d;
      empty    <= (depth_d == 4'd0);
      full     <= (depth_d == DEPTH_L);
      err      <= err_d;
      err_code <= err_code_d;
    end
  end

  assign top    = s_q[0];
  assign second = s_q[1];

  // CMD_SWAP is only referenced by the optional branch; keep it visibly used.
  logic unused_swap;
  assign unused_swap = ^CMD_SWAP;

endmodule

// File: tb/tb_rpn_operand_stack.sv
// Self-checking bench for rpn_operand_stack: directed scenarios followed by
// random commands, all compared against a queue-based reference stack.
module tb_rpn_operand_stack;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic [7:0] din;
  logic [7:0] top;
  logic [7:0] second;
  logic [3:0] depth;
  logic       empty;
  logic       full;
  logic       err;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;

  // Reference model: q[0] is the top of stack.
  logic [7:0] q[$];
  logic       m_err;
  logic [1:0] m_code;

  rpn_operand_stack #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd), .din(din),
    .top(top), .second(second), .depth(depth), .empty(empty), .full(full),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] e_top, e_sec;
    e_top = (q.size() > 0) ? q[0] : 8'h00;
    e_sec = (q.size() > 1) ? q[1] : 8'h00;
    chk({tag, ".top"}, top, e_top);
    chk({tag, ".second"}, second, e_sec);
    chk({tag, ".depth"}, {4'h0, depth}, 8'(q.size()));
    chk({tag, ".empty"}, {7'h0, empty}, {7'h0, (q.size() == 0)});
    chk({tag, ".full"}, {7'h0, full}, {7'h0, (q.size() == DEPTH)});
    chk({tag, ".err"}, {7'h0, err}, {7'h0, m_err});
    chk({tag, ".err_code"}, {6'h0, err_code}, {6'h0, m_code});
  endtask

  // Apply the command rules directly to the queue.
  task automatic model(input logic v, input logic [2:0] c, input logic [7:0] d);
    logic [7:0] t;
    m_err = 1'b0;
    if (v) begin
      case (c)
        3'd1: if (q.size() == DEPTH) begin m_err = 1; m_code = 2'b01; end
              else q.push_front(d);
        3'd2: if (q.size() == 0) begin m_err = 1; m_code = 2'b10; end
              else t = q.pop_front();
        3'd3: if (q.size() < 2) begin m_err = 1; m_code = 2'b10; end
              else begin t = q.pop_front(); t = q.pop_front(); q.push_front(d); end
        3'd4: begin q.delete(); m_code = 2'b00; end
`ifdef RPN_STACK_SWAP_EN
        3'd5: if (q.size() < 2) begin m_err = 1; m_code = 2'b10; end
              else begin t = q[0]; q[0] = q[1]; q[1] = t; end
`else
        3'd5: begin m_err = 1; m_code = 2'b11; end
`endif
        3'd6, 3'd7: begin m_err = 1; m_code = 2'b11; end
        default: ;
      endcase
    end
  endtask

  task automatic step(input string tag, input logic v, input logic [2:0] c, input logic [7:0] d);
    @(negedge clk);
    cmd_valid = v; cmd = c; din = d;
    model(v, c, d);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [2:0] rc;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd = 3'd0; din = 8'h00;
    m_err = 1'b0; m_code = 2'b00;
    #12;
    check_all("reset");
    @(negedge clk); rst_n = 1'b1;

    step("push3a", 1, 3'd1, 8'h3A);
    step("pushc5", 1, 3'd1, 8'hC5);
    chk("plan1.top", top, 8'hC5);
    chk("plan1.second", second, 8'h3A);

    step("clr1", 1, 3'd4, 8'h00);
    for (int i = 1; i <= 4; i++) step("fill", 1, 3'd1, 8'(i));
    step("overflow", 1, 3'd1, 8'h05);
    chk("ovf.code", {6'h0, err_code}, 8'h01);
    step("after_ovf", 1, 3'd0, 8'h00);
    chk("ovf.pulse_end", {7'h0, err}, 8'h00);

    step("clr2", 1, 3'd4, 8'h00);
    step("push07", 1, 3'd1, 8'h07);
    step("push05", 1, 3'd1, 8'h05);
    step("binop0c", 1, 3'd3, 8'h0C);
    chk("binop.top", top, 8'h0C);
    step("binop_under", 1, 3'd3, 8'h0D);
    chk("binop_under.top", top, 8'h0C);

    step("clr3", 1, 3'd4, 8'h00);
    step("pop_empty", 1, 3'd2, 8'h00);
    chk("pop_empty.code", {6'h0, err_code}, 8'h02);
    step("clr4", 1, 3'd4, 8'h00);

    step("push11", 1, 3'd1, 8'h11);
    step("push22", 1, 3'd1, 8'h22);
    step("swap", 1, 3'd5, 8'h00);
    step("ill6", 1, 3'd6, 8'h99);
    step("ill7_noval", 0, 3'd7, 8'h99);

    // Asynchronous reset between edges.
    step("clr5", 1, 3'd4, 8'h00);
    for (int i = 0; i < 3; i++) step("pre_rst", 1, 3'd1, 8'(8'hA0 + i));
    @(posedge clk); #3;
    rst_n = 1'b0;
    q.delete(); m_err = 1'b0; m_code = 2'b00;
    #1;
    check_all("async_rst");
    @(negedge clk); cmd_valid = 1'b0; rst_n = 1'b1;

    // Random commands against the model; CLEAR is thinned out so the stack fills up.
    for (int n = 0; n < 400; n++) begin
      rc = 3'($urandom_range(0, 7));
      if (rc == 3'd4 && $urandom_range(0, 3) != 0) rc = 3'd1;
      step("rand", ($urandom_range(0, 4) != 0), rc, 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
